// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: ICache miss refill sequencer (line request, beat fill, tag commit, victim select).
// Define ICACHE_REFILL_CWF_EN for critical-word-first bursts with early instruction delivery.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module icache_refill_ctrl #(
  parameter int IndexBits  = 6,
  parameter int OffsetBits = 6,
  parameter int NumWays    = 8,
  localparam int WayBits      = (NumWays > 1) ? $clog2(NumWays) : 1,
  localparam int WordBits     = OffsetBits - 2,
  localparam int WordsPerLine = 2 ** WordBits,
  localparam int TagBits      = `INST_WIDTH - IndexBits - OffsetBits
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [`INST_WIDTH-1:0] miss_addr,
  output logic                   miss_ready,
  output logic                   mem_req_valid,
  output logic [`INST_WIDTH-1:0] mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [`INST_WIDTH-1:0] mem_resp_data,
  input  logic                   mem_resp_last,
  input  logic                   mem_resp_err,
  output logic                   data_we,
  output logic [WayBits-1:0]     data_way,
  output logic [IndexBits-1:0]   data_index,
  output logic [WordBits-1:0]    data_word,
  output logic [`INST_WIDTH-1:0] data_wdata,
  output logic                   tag_we,
  output logic [WayBits-1:0]     tag_way,
  output logic [IndexBits-1:0]   tag_index,
  output logic [TagBits-1:0]     tag_value,
  output logic                   inst_valid,
  output logic [`INST_WIDTH-1:0] inst_data,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [`INST_WIDTH-1:0] addr_q;
  logic [WordBits-1:0]    cnt_q;
  logic [WayBits-1:0]     victim_q;
  logic                   err_q;
  logic [`INST_WIDTH-1:0] inst_data_q;
`ifdef ICACHE_REFILL_CWF_EN
  logic                   inst_valid_q;
`endif

  logic                   beat, last_idx, beat_bad, beat_ok, beat_abort;
  logic [WordBits-1:0]    miss_word, start_word, cur_word;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^addr_q[1:0];
  assign miss_word        = addr_q[OffsetBits-1:2];
`ifdef ICACHE_REFILL_CWF_EN
  assign start_word       = miss_word;
`else
  assign start_word       = '0;
`endif
  assign cur_word         = start_word + cnt_q;

  // A beat is bad if flagged, or if 'last' disagrees with the beat position.
  assign beat       = (state_q == FILL) && mem_resp_valid;
  assign last_idx   = (cnt_q == WordBits'(WordsPerLine - 1));
  assign beat_bad   = mem_resp_err || (mem_resp_last != last_idx);
  assign beat_ok    = beat && !beat_bad;
  assign beat_abort = beat && beat_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_valid) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = FILL;
      FILL: begin
        if (beat_abort)            state_d = IDLE;
        else if (beat_ok && last_idx) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      cnt_q       <= '0;
      victim_q    <= '0;
      err_q       <= 1'b0;
      inst_data_q <= '0;
`ifdef ICACHE_REFILL_CWF_EN
      inst_valid_q <= 1'b0;
`endif
    end else begin
      err_q <= beat_abort;
      if (state_q == IDLE && miss_valid) addr_q <= miss_addr;
      if (state_q == REQ && mem_req_ready) cnt_q <= '0;
      else if (beat_ok)                    cnt_q <= cnt_q + WordBits'(1);
      if (state_q == COMMIT)
        victim_q <= (victim_q == WayBits'(NumWays - 1)) ? '0 : victim_q + WayBits'(1);
`ifdef ICACHE_REFILL_CWF_EN
      // First beat of a wrapped burst is the missed word itself.
      inst_valid_q <= beat_ok && (cnt_q == '0);
      if (beat_ok && cnt_q == '0) inst_data_q <= mem_resp_data;
`else
      if (beat_ok && cur_word == miss_word) inst_data_q <= mem_resp_data;
`endif
    end
  end

  always_comb begin
    miss_ready    = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    busy          = (state_q != IDLE);
`ifdef ICACHE_REFILL_CWF_EN
    mem_req_addr  = {addr_q[`INST_WIDTH-1:2], 2'b00};
`else
    mem_req_addr  = {addr_q[`INST_WIDTH-1:OffsetBits], {OffsetBits{1'b0}}};
`endif
    data_we       = beat_ok;
    data_way      = victim_q;
    data_index    = addr_q[OffsetBits +: IndexBits];
    data_word     = cur_word;
    data_wdata    = beat_ok ? mem_resp_data : '0;
    tag_we        = (state_q == COMMIT);
    tag_way       = victim_q;
    tag_index     = addr_q[OffsetBits +: IndexBits];
    tag_value     = addr_q[`INST_WIDTH-1 -: TagBits];
    err           = err_q;
`ifdef ICACHE_REFILL_CWF_EN
    inst_valid    = inst_valid_q;
    inst_data     = inst_data_q;
`else
    inst_valid    = (state_q == COMMIT);
    inst_data     = (state_q == COMMIT) ? inst_data_q : '0;
`endif
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: table of miss scenarios plus hand sequences,
// with a scoreboard of expected array writes, tag commits, instruction deliveries and errors.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module tb_icache_refill_ctrl;
`ifdef ICACHE_REFILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid, miss_ready, mem_req_valid, mem_req_ready;
  logic [31:0] miss_addr, mem_req_addr, mem_resp_data, data_wdata, inst_data;
  logic        mem_resp_valid, mem_resp_last, mem_resp_err;
  logic        data_we, tag_we, inst_valid, busy, err;
  logic [2:0]  data_way, tag_way;
  logic [5:0]  data_index, tag_index;
  logic [3:0]  data_word;
  logic [19:0] tag_value;

  icache_refill_ctrl #(.IndexBits(6), .OffsetBits(6), .NumWays(8)) dut (
    .clk(clk), .rst(rst),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_last(mem_resp_last), .mem_resp_err(mem_resp_err),
    .data_we(data_we), .data_way(data_way), .data_index(data_index),
    .data_word(data_word), .data_wdata(data_wdata),
    .tag_we(tag_we), .tag_way(tag_way), .tag_index(tag_index), .tag_value(tag_value),
    .inst_valid(inst_valid), .inst_data(inst_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [3:0] word; logic [31:0] wdata; logic [5:0] index; logic [2:0] way; int unsigned at;} wr_t;
  typedef struct {logic [19:0] tag; logic [5:0] index; logic [2:0] way; int unsigned at;} tg_t;
  typedef struct {logic [31:0] data; int unsigned at;} in_t;
  typedef struct {
    logic [31:0] addr; int err_beat; int last_beat; int stall; int req_stall; bit chk_lat;
    logic [5:0] idx; logic [19:0] tag; logic [31:0] line; logic [3:0] word;
  } vec_t;

  wr_t         wr_q[$];
  tg_t         tg_q[$];
  in_t         in_q[$];
  int unsigned er_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [2:0]  vict = '0;
  vec_t        vt[7];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
  endfunction

  // Scoreboard: every observed event must match the oldest expectation in its queue.
  always @(negedge clk) begin
    wr_t e; tg_t t; in_t n; int unsigned r;
    if (!rst) begin
      if (data_we) begin
        check("data_we_expected", 96'(data_we), 96'(wr_q.size() != 0));
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("data_write", {data_word, data_wdata, data_index, data_way, cyc},
                {e.word, e.wdata, e.index, e.way, e.at});
        end
      end
      if (tag_we) begin
        check("tag_we_expected", 96'(tag_we), 96'(tg_q.size() != 0));
        if (tg_q.size() != 0) begin
          t = tg_q.pop_front();
          check("tag_write", {tag_value, tag_index, tag_way, cyc}, {t.tag, t.index, t.way, t.at});
        end
      end
      if (inst_valid) begin
        check("inst_expected", 96'(inst_valid), 96'(in_q.size() != 0));
        if (in_q.size() != 0) begin
          n = in_q.pop_front();
          check("inst_deliver", {inst_data, cyc}, {n.data, n.at});
        end
      end
      if (err) begin
        check("err_expected", 96'(err), 96'(er_q.size() != 0));
        if (er_q.size() != 0) begin
          r = er_q.pop_front();
          check("err_pulse_time", 96'(cyc), 96'(r));
        end
      end
    end
  end

  task automatic wait_idle(input string name, output int unsigned at);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (miss_ready) break;
    end
    check(name, 96'(miss_ready), 96'(1));
    at = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vict = '0;
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; mem_resp_err = 1'b0;
    mem_req_ready = 1'b0; miss_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_miss(input vec_t v);
    logic [31:0] ereq, d;
    logic [3:0]  w;
    int unsigned acc, at;
    bit          abort;
    wait_idle("idle_before_miss", at);
    @(posedge clk); #1;
    miss_valid = 1'b1; miss_addr = v.addr;
    @(posedge clk); #1;
    miss_valid = 1'b0; miss_addr = $urandom;
    acc = cyc;
    ereq = CWF ? {v.addr[31:2], 2'b00} : v.line;
    check("req_after_accept", {busy, miss_ready, mem_req_valid, mem_req_addr}, {1'b1, 1'b0, 1'b1, ereq});
    for (int i = 0; i < v.req_stall; i++) begin
      mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_data = $urandom;
      @(posedge clk); #1;
      check("req_hold", {mem_req_valid, mem_req_addr}, {1'b1, ereq});
    end
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    abort = 1'b0;
    for (int b = 0; b < 16 && !abort; b++) begin
      if (v.stall > 0 && b % 2 == 1) begin
        mem_resp_valid = 1'b0; mem_resp_data = $urandom;
        repeat (v.stall) begin @(posedge clk); #1; end
      end
      w = CWF ? v.word + 4'(b) : 4'(b);
      d = mem_word(v.line | (32'(w) << 2));
      mem_resp_valid = 1'b1; mem_resp_data = d;
      mem_resp_last = (b == v.last_beat); mem_resp_err = (b == v.err_beat);
      if (b == v.err_beat || (b == v.last_beat) != (b == 15)) begin
        abort = 1'b1;
        er_q.push_back(cyc + 1);
      end else begin
        wr_q.push_back('{w, d, v.idx, vict, cyc});
        if (CWF && b == 0) in_q.push_back('{d, cyc + 1});
        if (b == 15) begin
          tg_q.push_back('{v.tag, v.idx, vict, cyc + 1});
          if (!CWF) in_q.push_back('{mem_word(v.line | (32'(v.word) << 2)), cyc + 1});
          vict = vict + 3'd1;
        end
      end
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0; mem_resp_err = 1'b0;
    wait_idle("idle_after_miss", at);
    if (v.chk_lat) check("miss_to_idle_cycles", 96'(at - acc), 96'(18));
    #1;
    check("events_drained", 96'(wr_q.size() + tg_q.size() + in_q.size() + er_q.size()), 96'(0));
    check("busy_when_idle", 96'(busy), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    miss_addr = '0; mem_resp_data = '0;
    vt[0] = '{32'h0000_1244, -1, 15, 0, 0, 1'b1, 6'h09, 20'h00001, 32'h0000_1240, 4'd1};
    vt[1] = '{32'hDEAD_BEEC, -1, 15, 2, 3, 1'b0, 6'h3B, 20'hDEADB, 32'hDEAD_BEC0, 4'd11};
    vt[2] = '{32'h0000_0000,  5, 15, 0, 0, 1'b0, 6'h00, 20'h00000, 32'h0000_0000, 4'd0};
    vt[3] = '{32'hFFFF_FFFC, -1, 15, 1, 1, 1'b0, 6'h3F, 20'hFFFFF, 32'hFFFF_FFC0, 4'd15};
    vt[4] = '{32'h1234_5678, -1,  9, 0, 0, 1'b0, 6'h19, 20'h12345, 32'h1234_5640, 4'd14};
    vt[5] = '{32'h0000_1244, -1, 16, 0, 0, 1'b0, 6'h09, 20'h00001, 32'h0000_1240, 4'd1};
    vt[6] = '{32'h0000_0000,  0, 15, 0, 0, 1'b0, 6'h00, 20'h00000, 32'h0000_0000, 4'd0};

    do_reset();
    @(negedge clk);
    check("reset_outputs",
          {miss_ready, busy, mem_req_valid, mem_req_addr, data_we, tag_we, inst_valid, err, tag_way, tag_value},
          {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 20'h0});

    // Response beats while idle must be ignored.
    @(posedge clk); #1;
    mem_resp_valid = 1'b1; mem_resp_last = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    repeat (3) begin @(posedge clk); #1; check("idle_ignores_resp", {miss_ready, busy, data_we}, {1'b1, 1'b0, 1'b0}); end
    mem_resp_valid = 1'b0; mem_resp_last = 1'b0;

    for (int i = 0; i < 7; i++) run_miss(vt[i]);

    // Back-to-back successful misses cycle through every victim way.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      v.tag = 20'h00100 + 20'(i); v.idx = 6'(i * 7); v.word = 4'(i + 3);
      v.line = {v.tag, v.idx, 6'b0};
      v.addr = v.line | (32'(v.word) << 2) | 32'(i % 4);
      v.err_beat = -1; v.last_beat = 15; v.stall = i % 2; v.req_stall = 0; v.chk_lat = (i % 2 == 0);
      run_miss(v);
    end

    // Reset in the middle of a fill abandons the line; the next refill uses way 0.
    check("victim_nonzero_before_reset", 96'(vict), 96'(1));
    begin
      int unsigned at;
      logic [31:0] d;
      wait_idle("idle_before_reset_test", at);
      @(posedge clk); #1;
      miss_valid = 1'b1; miss_addr = 32'h0000_1244;
      @(posedge clk); #1;
      miss_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int b = 0; b < 8; b++) begin
        d = mem_word(32'h0000_1240 | (32'((CWF ? 1 : 0) + b) << 2));
        mem_resp_valid = 1'b1; mem_resp_data = d; mem_resp_last = 1'b0;
        wr_q.push_back('{4'((CWF ? 1 : 0) + b), d, 6'h09, vict, cyc});
        @(posedge clk); #1;
      end
      mem_resp_data = 32'h1111_2222;
      #1 rst = 1'b1;
      #1 check("outputs_in_reset", {busy, miss_ready, data_we, tag_we, mem_req_valid},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
      vict = '0;
      mem_resp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_drops_partial_line", 96'(wr_q.size() + tg_q.size() + in_q.size()), 96'(0));
      v = vt[0];
      v.chk_lat = 1'b1;
      run_miss(v);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
